// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD bus controller: turns START edges in the core's LCD
// word into timed RS/EN/DATA write cycles plus command exec waits, with optional power-on init.
module lcd_ctrl #(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned EN_HIGH_CYC   = 12,
    parameter int unsigned HOLD_CYC      = 2,
    parameter int unsigned EXEC_CYC      = 2500,
    parameter int unsigned SLOW_EXEC_CYC = 82000,
    parameter int unsigned POWERUP_CYC   = 750000,
    parameter int unsigned INIT_EN       = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_done
);
    localparam int unsigned MAX_A = (POWERUP_CYC > SLOW_EXEC_CYC) ? POWERUP_CYC : SLOW_EXEC_CYC;
    localparam int unsigned MAX_B = (EXEC_CYC > EN_HIGH_CYC) ? EXEC_CYC : EN_HIGH_CYC;
    localparam int unsigned MAX_C = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAXC  = (MAX_D > MAX_C) ? MAX_D : MAX_C;
    localparam int          CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_SETUP, S_EN_HI, S_HOLD, S_EXEC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    word_q, word_d;        // {RS, DATA} of the transfer on the bus
    logic [8:0]    pend_word_q, pend_word_d;
    logic          pend_q, pend_d;
    logic          init_q, init_d;
    logic [1:0]    idx_q, idx_d;
    logic          done_q, done_d;
    logic          start_prev_q, on_q;
    logic          req, cnt_zero;
    logic [8:0]    req_word;
    logic          unused_bits;

    function automatic logic [CW-1:0] ld(input int unsigned n);
        return (n == 0) ? '0 : CW'(n - 1);
    endfunction

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Clear-display / return-home need the long execution wait.
    function automatic logic is_slow(input logic [8:0] w);
        return ~w[8] && (w[7:2] == 6'd0) && (w[7:0] != 8'd0);
    endfunction

    assign req         = i_lcd_word[10] & ~start_prev_q;
    assign req_word    = {i_lcd_word[9], i_lcd_word[7:0]};
    assign cnt_zero    = (cnt_q == '0);
    assign unused_bits = ^{i_lcd_word[30:11], i_lcd_word[8]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_zero ? '0 : cnt_q - CW'(1);
        word_d      = word_q;
        pend_d      = pend_q;
        pend_word_d = pend_word_q;
        init_d      = init_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        if (req) begin
            pend_d      = 1'b1;
            pend_word_d = req_word;
        end
        case (state_q)
            S_PWRUP: if (cnt_zero) state_d = S_INIT;
            S_INIT: begin
                word_d  = {1'b0, init_rom(idx_q)};
                init_d  = 1'b1;
                state_d = S_SETUP;
                cnt_d   = ld(SETUP_CYC);
            end
            S_IDLE: begin
                // A fresh edge here supersedes any pending word (one-deep, last wins).
                pend_d = 1'b0;
                if (req) begin
                    word_d  = req_word;
                    state_d = S_SETUP;
                    cnt_d   = ld(SETUP_CYC);
                end else if (pend_q) begin
                    word_d  = pend_word_q;
                    state_d = S_SETUP;
                    cnt_d   = ld(SETUP_CYC);
                end
            end
            S_SETUP: if (cnt_zero) begin
                state_d = S_EN_HI;
                cnt_d   = ld(EN_HIGH_CYC);
            end
            S_EN_HI: if (cnt_zero) begin
                state_d = S_HOLD;
                cnt_d   = ld(HOLD_CYC);
            end
            S_HOLD: if (cnt_zero) begin
                state_d = S_EXEC;
                cnt_d   = is_slow(word_q) ? ld(SLOW_EXEC_CYC) : ld(EXEC_CYC);
            end
            S_EXEC: if (cnt_zero) begin
                state_d = S_IDLE;
                if (init_q) begin
                    if (idx_q != 2'd3) begin
                        state_d = S_INIT;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        init_d = 1'b0;
                        idx_d  = 2'd0;
                    end
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (INIT_EN != 0) begin
                state_q <= S_PWRUP;
                cnt_q   <= ld(POWERUP_CYC);
            end else begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end
            word_q       <= '0;
            pend_word_q  <= '0;
            pend_q       <= 1'b0;
            init_q       <= 1'b0;
            idx_q        <= 2'd0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b0;
            on_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            pend_word_q  <= pend_word_d;
            pend_q       <= pend_d;
            init_q       <= init_d;
            idx_q        <= idx_d;
            done_q       <= done_d;
            start_prev_q <= i_lcd_word[10];
            on_q         <= i_lcd_word[31];
        end
    end

    assign o_lcd_data = word_q[7:0];
    assign o_lcd_rs   = word_q[8];
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = (state_q == S_EN_HI);
    assign o_lcd_on   = on_q;
    assign o_busy     = (state_q != S_IDLE) | pend_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: two instances (with and without power-on init) checked every
// cycle against a transfer-timeline model, plus hand-computed literal expectations.
module tb_lcd_ctrl;
    localparam int S = 2, E = 3, H = 1, X = 5, SX = 20, P = 10;
    localparam int PH_PWR = 0, PH_GAP = 1, PH_IDLE = 2, PH_XFER = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1 = 1'b0, rst0 = 1'b0;
    logic [31:0] w1 = '0, w0 = '0;
    logic [7:0]  dat1, dat0;
    logic        rs1, rw1, en1, on1, b1, dn1;
    logic        rs0, rw0, en0, on0, b0, dn0;

    lcd_ctrl #(.SETUP_CYC(S), .EN_HIGH_CYC(E), .HOLD_CYC(H), .EXEC_CYC(X),
               .SLOW_EXEC_CYC(SX), .POWERUP_CYC(P), .INIT_EN(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst1), .i_lcd_word(w1), .o_lcd_data(dat1), .o_lcd_rs(rs1),
        .o_lcd_rw(rw1), .o_lcd_en(en1), .o_lcd_on(on1), .o_busy(b1), .o_done(dn1));

    lcd_ctrl #(.SETUP_CYC(S), .EN_HIGH_CYC(E), .HOLD_CYC(H), .EXEC_CYC(X),
               .SLOW_EXEC_CYC(SX), .POWERUP_CYC(P), .INIT_EN(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst0), .i_lcd_word(w0), .o_lcd_data(dat0), .o_lcd_rs(rs0),
        .o_lcd_rw(rw0), .o_lcd_en(en0), .o_lcd_on(on0), .o_busy(b0), .o_done(dn0));

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Model: a transfer is a timeline of S+E+H+exec cycles starting at SETUP entry.
    typedef struct {
        int         ph;
        int         pw;
        int         e;
        logic [8:0] cur;
        bit         cur_init;
        int         idx;
        bit         pend;
        logic [8:0] pword;
        bit         sp;
        bit         on;
        bit         done;
    } mdl_t;

    logic [7:0] init_words [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    mdl_t m1, m0;

    function automatic int xfer_len(input logic [8:0] w);
        bit slow;
        slow = !w[8] && (w[7:0] inside {8'h01, 8'h02, 8'h03});
        return S + E + H + (slow ? SX : X);
    endfunction

    function automatic mdl_t mnext(input mdl_t c, input logic rst_n, input logic [31:0] w,
                                   input bit init_en);
        mdl_t m;
        bit req;
        logic [8:0] rq;
        m = c;
        if (!rst_n) begin
            m = '{default: 0};
            m.ph = init_en ? PH_PWR : PH_IDLE;
            return m;
        end
        req    = w[10] && !m.sp;
        rq     = {w[9], w[7:0]};
        m.sp   = w[10];
        m.on   = w[31];
        m.done = 1'b0;
        if (m.ph == PH_IDLE) begin
            if (req || m.pend) begin
                m.cur = req ? rq : m.pword;
                m.cur_init = 1'b0;
                m.e = 0;
                m.ph = PH_XFER;
            end
            m.pend = 1'b0;
        end else begin
            if (req) begin
                m.pend = 1'b1;
                m.pword = rq;
            end
            if (m.ph == PH_PWR) begin
                m.pw++;
                if (m.pw == P) m.ph = PH_GAP;
            end else if (m.ph == PH_GAP) begin
                m.cur = {1'b0, init_words[m.idx]};
                m.cur_init = 1'b1;
                m.e = 0;
                m.ph = PH_XFER;
            end else begin
                m.e++;
                if (m.e == xfer_len(m.cur)) begin
                    if (m.cur_init) begin
                        m.idx++;
                        m.ph = (m.idx == 4) ? PH_IDLE : PH_GAP;
                    end else begin
                        m.ph = PH_IDLE;
                        m.done = 1'b1;
                    end
                end
            end
        end
        return m;
    endfunction

    always @(posedge clk) begin
        m1 <= mnext(m1, rst1, w1, 1'b1);
        m0 <= mnext(m0, rst0, w0, 1'b0);
    end

    task automatic cmp(input string nm, input mdl_t m, input logic busy, input logic en,
                       input logic done, input logic on, input logic rw, input logic rs,
                       input logic [7:0] dat);
        bit xf;
        xf = (m.ph == PH_XFER);
        chk({nm, ".busy"}, busy, (m.ph != PH_IDLE) || m.pend);
        chk({nm, ".en"}, en, xf && m.e >= S && m.e < S + E);
        chk({nm, ".done"}, done, m.done);
        chk({nm, ".on"}, on, m.on);
        chk({nm, ".rw"}, rw, 1'b0);
        if (xf && m.e < S + E + H) begin
            chk({nm, ".data"}, dat, m.cur[7:0]);
            chk({nm, ".rs"}, rs, m.cur[8]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("d1", m1, b1, en1, dn1, on1, rw1, rs1, dat1);
            cmp("d0", m0, b0, en0, dn0, on0, rw0, rs0, dat0);
        end
    end

    // Monitors: EN pulse data, done pulses, length of the last completed busy run.
    int en_cnt1 = 0, en_cnt0 = 0, done_cnt1 = 0, done_cnt0 = 0;
    int run1 = 0, run0 = 0, last_run1 = 0, last_run0 = 0;
    logic en1_p = 1'b0, en0_p = 1'b0;
    logic [7:0] en_dat1 [$];
    logic [7:0] en_dat0 [$];

    always @(negedge clk) begin
        if (en1 === 1'b1 && !en1_p) begin en_cnt1 <= en_cnt1 + 1; en_dat1.push_back(dat1); end
        if (en0 === 1'b1 && !en0_p) begin en_cnt0 <= en_cnt0 + 1; en_dat0.push_back(dat0); end
        en1_p <= (en1 === 1'b1);
        en0_p <= (en0 === 1'b1);
        if (dn1 === 1'b1) done_cnt1 <= done_cnt1 + 1;
        if (dn0 === 1'b1) done_cnt0 <= done_cnt0 + 1;
        if (b1 === 1'b1) run1 <= run1 + 1;
        else if (run1 != 0) begin last_run1 <= run1; run1 <= 0; end
        if (b0 === 1'b1) run0 <= run0 + 1;
        else if (run0 != 0) begin last_run0 <= run0; run0 <= 0; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit sel, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while ((sel ? b1 : b0) !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".idle_within_bound"}, n < 400, 1'b1);
        #1;
    endtask

    task automatic pulse0(input logic [31:0] w);
        w0 = w;
        tick(1);
        w0 = w & ~32'h400;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst.busy1", b1, 1'b1);
        chk("rst.busy0", b0, 1'b0);
        chk("rst.en1", en1, 1'b0);
        chk("rst.data1", dat1, 8'h00);
        chk("rst.done0", dn0, 1'b0);
        tick(2);
        rst1 = 1'b1;
        rst0 = 1'b1;

        // Init: 2 reset cycles + 10 PWRUP + 4 INIT gaps + 3*11 + 26 = 75 busy cycles
        wait_idle(1'b1, "init");
        chk("init.busy_run", last_run1, 75);
        chk("init.en_pulses", en_cnt1, 4);
        chk("init.w0", en_dat1[0], 8'h38);
        chk("init.w1", en_dat1[1], 8'h0C);
        chk("init.w2", en_dat1[2], 8'h01);
        chk("init.w3", en_dat1[3], 8'h06);
        chk("init.no_done", done_cnt1, 0);

        // Single data write 0x41, RS=1: 2+3+1+5 = 11 busy cycles
        tick(1);
        pulse0(32'h0000_0641);
        wait_idle(1'b0, "wr41");
        chk("wr41.busy_run", last_run0, 11);
        chk("wr41.done", done_cnt0, 1);
        chk("wr41.en_pulses", en_cnt0, 1);
        chk("wr41.data", en_dat0[0], 8'h41);

        // Clear display: 2+3+1+20 = 26
        tick(2);
        pulse0(32'h0000_0401);
        wait_idle(1'b0, "clr");
        chk("clr.busy_run", last_run0, 26);
        chk("clr.done", done_cnt0, 2);
        chk("clr.data", en_dat0[1], 8'h01);

        // Two requests while busy: last wins, busy contiguous 11 + 1 pending-idle + 11
        tick(2);
        pulse0(32'h0000_0641);
        tick(1);
        pulse0(32'h0000_0642);
        tick(1);
        pulse0(32'h0000_0643);
        wait_idle(1'b0, "pend");
        chk("pend.busy_run", last_run0, 23);
        chk("pend.done", done_cnt0, 4);
        chk("pend.en_pulses", en_cnt0, 4);
        chk("pend.first", en_dat0[2], 8'h41);
        chk("pend.last_wins", en_dat0[3], 8'h43);

        // START held high 50 cycles: one transfer only
        tick(2);
        w0 = 32'h0000_0648;
        tick(50);
        w0 = 32'h0000_0248;
        tick(2);
        chk("hold.en_pulses", en_cnt0, 5);
        chk("hold.done", done_cnt0, 5);
        chk("hold.data", en_dat0[4], 8'h48);
        chk("hold.busy_run", last_run0, 11);

        // ON bit alone: 1-cycle latency, no bus activity
        w0 = 32'h8000_0248;
        @(negedge clk);
        chk("on.before_edge", on0, 1'b0);
        @(negedge clk);
        chk("on.after_edge", on0, 1'b1);
        #1;
        w0 = 32'h0000_0248;
        @(negedge clk);
        chk("on.cleared", on0, 1'b0);
        tick(2);
        chk("on.no_en", en_cnt0, 5);
        chk("on.idle", b0, 1'b0);

        // Reset during 2nd EN_HI cycle with a request pending
        w1 = 32'h0000_0641;
        tick(1);
        w1 = 32'h0000_0241;
        tick(1);
        w1 = 32'h0000_0642;
        tick(1);
        w1 = 32'h0000_0242;
        @(negedge clk);
        chk("mid.en_hi1", en1, 1'b1);
        tick(1);
        rst1 = 1'b0;
        @(negedge clk);
        chk("mid.en_hi2", en1, 1'b1);
        @(negedge clk);
        chk("mid.en_dropped", en1, 1'b0);
        chk("mid.busy_reset", b1, 1'b1);
        chk("mid.data_reset", dat1, 8'h00);
        tick(1);
        rst1 = 1'b1;
        // 4 transfer cycles + 1 reset cycle + 73 init cycles
        wait_idle(1'b1, "reinit");
        chk("reinit.busy_run", last_run1, 78);
        tick(20);
        chk("reinit.en_pulses", en_cnt1, 9);
        chk("reinit.no_done", done_cnt1, 0);
        chk("reinit.w0", en_dat1[5], 8'h38);
        chk("reinit.w3", en_dat1[8], 8'h06);
        chk("reinit.idle", b1, 1'b0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- HD44780-style character LCD timing controller on the consumer side of the core's LCD output register.
- The core's LSU drives a 32-bit LCD word. This block detects a start strobe in that word and generates a correctly timed RS/RW/EN/DATA bus cycle followed by the command execution wait.
- It exposes busy/done status, which the core can map back into an input register.
- Optionally runs a power-on init sequence before accepting software transfers.

Parameters:
- SETUP_CYC, 4: cycles RS/DATA are stable before EN rises (t_AS).
- EN_HIGH_CYC, 12: cycles EN is held high (PW_EH).
- HOLD_CYC, 2: cycles RS/DATA are held after EN falls (t_H).
- EXEC_CYC, 2500: post-strobe wait for normal commands/data (50 us at 50 MHz).
- SLOW_EXEC_CYC, 82000: post-strobe wait for clear/home commands (1.64 ms).
- POWERUP_CYC, 750000: wait after reset before the init sequence (15 ms).
- INIT_EN, 1: 1 = run the init sequence after reset; 0 = go straight to IDLE.

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  synchronous, active-low reset
- i_lcd_word  in  32  LCD word from core: [31]=ON, [10]=START, [9]=RS, [7:0]=DATA; other bits ignored
- o_lcd_data  out  8  LCD data bus
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  read/write; tied 0 (write-only)
- o_lcd_en  out  1  enable strobe
- o_lcd_on  out  1  LCD power/backlight
- o_busy  out  1  1 while init or any transfer/exec is in progress, or a request is pending
- o_done  out  1  one-cycle pulse when a software transfer completes

Behaviour:
- Reset and clocking:
  - Single clock. Reset is synchronous and active-low: sampled only on the rising edge of i_clk when i_reset=0.
  - Reset values: o_lcd_data=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_done=0.
  - o_busy at reset: 1 if INIT_EN=1, else 0.
  - Internal state at reset: pending flag cleared, start_prev=0, counters cleared. State = PWRUP if INIT_EN=1, else IDLE.
- o_lcd_on: registered copy of i_lcd_word[31], 1-cycle latency. Independent of the FSM.
- Start detect: start_prev <= i_lcd_word[10] every cycle. A request fires when i_lcd_word[10]=1 and start_prev=0 (rising edge). A level held high does not retrigger.
- Request capture:
  - In IDLE, a request latches {RS, DATA} and the FSM enters SETUP on the next edge.
  - In any other state, a request sets the pending flag and latches {RS, DATA} into a pending buffer. This buffer is one-deep; a newer request overwrites it (last wins).
  - On IDLE entry with pending=1, the pending word is issued: pending clears and the FSM enters SETUP on the next edge without waiting for a new edge.
- States:
  - PWRUP: count POWERUP_CYC, then INIT.
  - INIT: issue the ROM words in order through SETUP/EN_HI/HOLD/EXEC: 0x38, 0x0C, 0x01, 0x06, all with RS=0. No o_done pulse for init words. Go to IDLE after the 4th word.
  - IDLE: o_busy=0 unless pending=1.
  - SETUP: o_lcd_data/o_lcd_rs driven from the latched word, o_lcd_en=0, for SETUP_CYC cycles.
  - EN_HI: o_lcd_en=1 for EN_HIGH_CYC cycles; data/RS stable.
  - HOLD: o_lcd_en=0, data/RS stable, for HOLD_CYC cycles.
  - EXEC: wait for the exec time, then IDLE, pulsing o_done=1 for exactly one cycle (software transfers only).
- Exec time:
  - SLOW_EXEC_CYC when RS=0 and DATA[7:2]=0 and DATA!=0 (clear/home: 0x01..0x03).
  - EXEC_CYC otherwise.
- Latency: the request edge at clock N puts the FSM in SETUP at N+1. o_busy is 1 from N+1 through the last EXEC cycle. o_done coincides with the first IDLE cycle, in which o_busy=0 (unless pending=1).
- Total busy cycles per transfer = SETUP_CYC + EN_HIGH_CYC + HOLD_CYC + exec.
- Counters: one down-counter, wide enough for max(POWERUP_CYC, SLOW_EXEC_CYC). Loaded with N-1 on state entry; the FSM advances when the count reaches 0.
- Data/RS do not change between SETUP entry and HOLD exit, even if i_lcd_word changes.
- Reset mid-transfer: o_lcd_en=0 on the next edge, transfer abandoned, pending dropped, init restarts (if INIT_EN=1).
- Simultaneous request edge and EXEC→IDLE transition: the request is treated as pending and issued from IDLE on the next edge. No request is lost.

Test Plan (SETUP_CYC=2, EN_HIGH_CYC=3, HOLD_CYC=1, EXEC_CYC=5, SLOW_EXEC_CYC=20, POWERUP_CYC=10):
1. INIT_EN=1, release reset:
   - o_busy=1 for 10 cycles of PWRUP, then 4 EN pulses of 3 cycles each carrying data 0x38, 0x0C, 0x01, 0x06 with RS=0.
   - Spacing uses exec 5/5/20/5. No o_done pulses; o_busy=0 afterwards.
2. INIT_EN=0, idle, write word 0x0000_0641 (START=1, RS=1, DATA=0x41):
   - SETUP 2 cycles, then EN high 3 cycles with data=0x41 and RS=1, HOLD 1 cycle, EXEC 5 cycles.
   - o_busy high for 11 cycles, then a single o_done pulse.
3. Clear command, word 0x0000_0401:
   - Busy for 2+3+1+20=26 cycles; RS=0 throughout.
4. During a busy transfer, pulse START with 0x42 then with 0x43:
   - After the first transfer completes, exactly one further transfer occurs, carrying 0x43.
   - Two o_done pulses total.
5. Hold START=1 for 50 cycles: exactly one transfer occurs. Then toggle bit 31 alone: o_lcd_on follows with 1-cycle latency and no EN activity.
6. Assert i_reset=0 on the 2nd cycle of EN_HI: at the next edge o_lcd_en=0, o_busy returns to its reset value, and the earlier pending request is dropped.
